gcd_job_feeder: RTL and testbench
=================================

// Module: gcd_job_feeder
// PURPOSE
//  Upstream stage of the GCD FSM+datapath core. Queues operand pairs in a
//  small FIFO and launches them one at a time on the core's Start/X_in/Y_in
//  interface. It waits for Done, captures the core's GCD output and holds it
//  until the consumer acknowledges. Only one job is in flight at a time.
// PARAMETERS
//  WIDTH    4   operand/result width; must match the GCD core
//  DEPTH    4   FIFO entries; power of 2, >=2
//  TIMEOUT  64  watchdog limit in cycles; used only with GCD_FEED_TIMEOUT_EN
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-low reset (0 = reset)
//  push       in   1      enqueue {X_push,Y_push} this cycle
//  X_push     in   WIDTH  operand X
//  Y_push     in   WIDTH  operand Y
//  full       out  1      count==DEPTH
//  count      out  log2(DEPTH)+1  queued jobs, excluding the in-flight job
//  drop       out  1      1-cycle pulse: push rejected (full or zero operand)
//  Start      out  1      to core Start
//  X_out      out  WIDTH  to core X_in
//  Y_out      out  WIDTH  to core Y_in
//  Done       in   1      from core Done
//  GCD_in     in   WIDTH  from core GCD_out
//  res_valid  out  1      result held and valid
//  res_gcd    out  WIDTH  captured GCD
//  res_err    out  1      result invalid (timeout); 0 when the macro is off
//  res_ack    in   1      consumer accepts result; sampled while res_valid=1
//  busy       out  1      FSM state != IDLE
// BEHAVIOUR
//  Reset (reset=0, async): FIFO empty, FSM=IDLE. All outputs go to 0
//   immediately, including Start. The core sees Start=0 without a clock edge.
//  Push rule: a push is accepted at a rising edge when push=1, full=0,
//   X_push!=0 and Y_push!=0.
//   Zero operand or full: the entry is dropped and drop pulses next cycle.
//   Zero operands are rejected because the core does not terminate on them.
//   A push and a dequeue in the same cycle are both honoured. Full is
//   evaluated before the dequeue, so a push while full is still dropped.
//  FSM:
//   IDLE:   count>0 -> dequeue head into X_out/Y_out, go to LAUNCH.
//   LAUNCH: Start=1; go to WAIT.
//   WAIT:   Start=1, X_out/Y_out stable. Done=1 -> res_gcd<=GCD_in,
//           res_valid<=1, go to HOLD.
//   HOLD:   Start=1 (core keeps Done/GCD_out). res_ack=1 -> res_valid<=0,
//           go to REST.
//   REST:   Start=0 for exactly 1 cycle so the core returns to idle;
//           go to IDLE.
//  Latency: with empty FIFO and idle FSM, push at edge N gives Start=1 after
//   edge N+2. Minimum spacing between launches is 4 cycles plus core time.
//  X_out/Y_out change only on dequeue and hold their value otherwise.
//  res_gcd/res_valid are stable while res_valid=1 and res_ack=0. Done seen in
//   any state other than WAIT is ignored.
//  FIFO pointers wrap modulo DEPTH; count saturates at DEPTH and never wraps.
// CONFIGURATION
//  GCD_FEED_TIMEOUT_EN defined:
//   - A cycle counter is cleared on entry to WAIT.
//   - If the counter reaches TIMEOUT without Done: res_gcd<=0, res_err<=1,
//     res_valid<=1, go to HOLD. Normal ack/REST flow then follows.
//   - res_err clears together with res_valid.
//  Undefined: no counter is built, res_err is tied to 0, and WAIT is left
//   only on Done.
// TESTING
//  1. reset=0 100ns, release, push (12,9) -> Start=1 with X_out=12, Y_out=9.
//     Model core: Done=1, GCD_in=3 -> res_valid=1, res_gcd=3. Pulse res_ack
//     -> one cycle with Start=0, then busy=0.
//  2. Hold res_ack=0, push 5 pairs back to back -> first launches, count
//     reaches 4, full=1. Fifth push lost only if issued while full=1; drop
//     pulses then.
//  3. Push (0,7) -> drop=1 for 1 cycle, count unchanged, no launch.
//  4. Keep res_ack=0 with a second job queued -> Start stays 1, no new
//     launch, X_out unchanged, until ack.
//  5. Assert reset=0 mid-WAIT between clock edges -> Start, res_valid and
//     busy drop to 0 immediately. After release count=0.
//  6. With GCD_FEED_TIMEOUT_EN, TIMEOUT=8 and Done held 0 -> after 8 WAIT
//     cycles res_valid=1, res_err=1, res_gcd=0.

Source files
------------

// File: rtl/gcd_job_feeder.sv
// gcd_job_feeder
//   Upstream stage of the GCD FSM+datapath core. Buffers operand pairs in a
//   small FIFO and launches them one at a time on the core's Start/X_in/Y_in
//   handshake. It waits for Done, captures GCD_out and holds the result until
//   the consumer acknowledges it. Only one job is in flight at a time.
//
// Parameters
//   WIDTH    operand/result width (must match the GCD core)
//   DEPTH    FIFO entries, power of 2, >= 2
//   TIMEOUT  watchdog limit in WAIT cycles (only with GCD_FEED_TIMEOUT_EN)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   push       in   enqueue {X_push,Y_push}
//   X_push     in   operand X
//   Y_push     in   operand Y
//   full       out  FIFO holds DEPTH jobs
//   count      out  queued jobs, excluding the in-flight job
//   drop       out  1-cycle pulse after a rejected push (full or zero operand)
//   Start      out  core Start
//   X_out      out  core X_in
//   Y_out      out  core Y_in
//   Done       in   core Done
//   GCD_in     in   core GCD_out
//   res_valid  out  result held and valid
//   res_gcd    out  captured GCD
//   res_err    out  result invalid because of a timeout
//   res_ack    in   consumer accepts the result (sampled while res_valid=1)
//   busy       out  FSM not idle
//
// Configuration
//   GCD_FEED_TIMEOUT_EN  builds the WAIT watchdog; otherwise res_err is 0.

module gcd_job_feeder #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         X_push,
  input  logic [WIDTH-1:0]         Y_push,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop,
  output logic                     Start,
  output logic [WIDTH-1:0]         X_out,
  output logic [WIDTH-1:0]         Y_out,
  input  logic                     Done,
  input  logic [WIDTH-1:0]         GCD_in,
  output logic                     res_valid,
  output logic [WIDTH-1:0]         res_gcd,
  output logic                     res_err,
  input  logic                     res_ack,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_param_check
    $error("gcd_job_feeder: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_HOLD, S_REST} state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_mem_x [DEPTH];
  logic [WIDTH-1:0]  r_mem_y [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_drop;
  logic              r_start;
  logic [WIDTH-1:0]  r_x;
  logic [WIDTH-1:0]  r_y;
  logic              r_valid;
  logic [WIDTH-1:0]  r_gcd;
  logic              w_full;
  logic              w_accept;
  logic              w_deq;

  // Full is taken from the pre-dequeue count, so a push while full is
  // dropped even if the FSM dequeues on the same edge.
  assign w_full   = (r_count == CNT_FULL);
  assign w_accept = push && !w_full && (X_push != '0) && (Y_push != '0);
  assign w_deq    = (r_state == S_IDLE) && (r_count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_drop <= push && !w_accept;
      if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_deq)    r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_accept, w_deq})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem_x[r_wr_ptr] <= X_push;
      r_mem_y[r_wr_ptr] <= Y_push;
    end
  end

`ifdef GCD_FEED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  logic [TW-1:0] r_tmo;
  logic          r_err;
`endif

  // Each state's actions take effect on the edge that leaves it, so Start
  // rises entering WAIT and falls entering REST, giving one low REST cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_gcd   <= '0;
`ifdef GCD_FEED_TIMEOUT_EN
      r_tmo   <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_deq) begin
            r_x     <= r_mem_x[r_rd_ptr];
            r_y     <= r_mem_y[r_rd_ptr];
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_start <= 1'b1;
`ifdef GCD_FEED_TIMEOUT_EN
          r_tmo   <= '0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (Done) begin
            r_gcd   <= GCD_in;
            r_valid <= 1'b1;
            r_state <= S_HOLD;
`ifdef GCD_FEED_TIMEOUT_EN
          end else if (r_tmo == TMO_LAST) begin
            r_gcd   <= '0;
            r_err   <= 1'b1;
            r_valid <= 1'b1;
            r_state <= S_HOLD;
          end else begin
            r_tmo   <= r_tmo + TMO_ONE;
`endif
          end
        end
        S_HOLD: begin
          if (res_ack) begin
            r_valid <= 1'b0;
            r_start <= 1'b0;
`ifdef GCD_FEED_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
            r_state <= S_REST;
          end
        end
        S_REST:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign full      = w_full;
  assign count     = r_count;
  assign drop      = r_drop;
  assign Start     = r_start;
  assign X_out     = r_x;
  assign Y_out     = r_y;
  assign res_valid = r_valid;
  assign res_gcd   = r_gcd;
  assign busy      = (r_state != S_IDLE);
`ifdef GCD_FEED_TIMEOUT_EN
  assign res_err   = r_err;
`else
  assign res_err   = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_job_feeder.sv
// Testbench for gcd_job_feeder: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model, with a model
// of the GCD core answering the Start handshake.

module tb_gcd_job_feeder;

  localparam int W          = 4;
  localparam int D          = 4;
  localparam int TB_TIMEOUT = 8;

  logic         clk;
  logic         reset;
  logic         push;
  logic [W-1:0] X_push;
  logic [W-1:0] Y_push;
  logic         full;
  logic [2:0]   count;
  logic         drop;
  logic         Start;
  logic [W-1:0] X_out;
  logic [W-1:0] Y_out;
  logic         Done;
  logic [W-1:0] GCD_in;
  logic         res_valid;
  logic [W-1:0] res_gcd;
  logic         res_err;
  logic         res_ack;
  logic         busy;

  gcd_job_feeder #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .push(push), .X_push(X_push), .Y_push(Y_push),
    .full(full), .count(count), .drop(drop), .Start(Start), .X_out(X_out),
    .Y_out(Y_out), .Done(Done), .GCD_in(GCD_in), .res_valid(res_valid),
    .res_gcd(res_gcd), .res_err(res_err), .res_ack(res_ack), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Core model: once Start is seen, answers after a random latency and keeps
  // Done/GCD while Start stays high. With Start low it emits stray Done
  // pulses that the feeder must ignore.
  bit core_hang = 1'b0;
  int core_cnt  = 0;
  int core_lat  = 1;

  always @(negedge clk) begin
    if (!reset) begin
      Done     = 1'b0;
      core_cnt = 0;
    end else if (Start) begin
      if (core_cnt == 0) core_lat = $urandom_range(1, 6);
      core_cnt++;
      Done   = !core_hang && (core_cnt >= core_lat);
      GCD_in = Done ? W'(gcd(int'(X_out), int'(Y_out))) : W'($urandom);
    end else begin
      core_cnt = 0;
      Done     = ($urandom_range(0, 7) == 0);
      GCD_in   = W'($urandom);
    end
  end

  // Reference model. Phases: 0 idle, 1 launching, 2 core running,
  // 3 result held, 4 one-cycle rest with Start low.
  int m_qx[$];
  int m_qy[$];
  int m_phase, m_x, m_y, m_start, m_valid, m_gcd, m_err, m_drop, m_waited;
  bit m_acc;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_qx.delete();
      m_qy.delete();
      m_phase = 0; m_x = 0; m_y = 0; m_start = 0; m_valid = 0;
      m_gcd = 0; m_err = 0; m_drop = 0; m_waited = 0;
    end else begin
      m_acc  = push && (m_qx.size() < D) && (X_push != 0) && (Y_push != 0);
      m_drop = push && !m_acc;
      case (m_phase)
        0: if (m_qx.size() > 0) begin
             m_x = m_qx.pop_front();
             m_y = m_qy.pop_front();
             m_phase = 1;
           end
        1: begin m_start = 1; m_waited = 0; m_phase = 2; end
        2: begin
             m_waited++;
             if (Done) begin
               m_gcd = gcd(m_x, m_y); m_valid = 1; m_phase = 3;
             end
`ifdef GCD_FEED_TIMEOUT_EN
             else if (m_waited == TB_TIMEOUT) begin
               m_gcd = 0; m_err = 1; m_valid = 1; m_phase = 3;
             end
`endif
           end
        3: if (res_ack) begin
             m_valid = 0; m_err = 0; m_start = 0; m_phase = 4;
           end
        default: m_phase = 0;
      endcase
      if (m_acc) begin
        m_qx.push_back(int'(X_push));
        m_qy.push_back(int'(Y_push));
      end
    end
  end

  always @(negedge clk) begin
    chk("Start", int'(Start), m_start);
    chk("X_out", int'(X_out), m_x);
    chk("Y_out", int'(Y_out), m_y);
    chk("count", int'(count), m_qx.size());
    chk("full", int'(full), int'(m_qx.size() == D));
    chk("drop", int'(drop), m_drop);
    chk("res_valid", int'(res_valid), m_valid);
    if (m_valid != 0) chk("res_gcd", int'(res_gcd), m_gcd);
    chk("res_err", int'(res_err), m_err);
    chk("busy", int'(busy), int'(m_phase != 0));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  int px[5];
  int py[5];
  bit seen;

  initial begin
    reset = 1'b0; push = 1'b0; X_push = '0; Y_push = '0; res_ack = 1'b0;
    #50;
    chk("rst_Start", int'(Start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(res_valid), 0);
    #50 reset = 1'b1;

    // Single job (12,9): Start two edges after the push, result 3.
    @(negedge clk); push = 1'b1; X_push = 4'd12; Y_push = 4'd9;
    @(negedge clk); push = 1'b0;
    @(posedge clk); #1;
    chk("t1_launch_start", int'(Start), 0);
    chk("t1_launch_busy", int'(busy), 1);
    @(posedge clk); #1;
    chk("t1_start", int'(Start), 1);
    chk("t1_x", int'(X_out), 12);
    chk("t1_y", int'(Y_out), 9);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk); seen = res_valid;
    end
    chk("t1_valid", int'(res_valid), 1);
    chk("t1_gcd", int'(res_gcd), 3);
    res_ack = 1'b1;
    @(posedge clk); #1;
    chk("t1_ack_valid", int'(res_valid), 0);
    chk("t1_rest_start", int'(Start), 0);
    chk("t1_rest_busy", int'(busy), 1);
    @(negedge clk); res_ack = 1'b0;
    @(posedge clk); #1;
    chk("t1_idle_busy", int'(busy), 0);
    chk("t1_idle_start", int'(Start), 0);

    // Zero operand is rejected.
    @(negedge clk); push = 1'b1; X_push = 4'd0; Y_push = 4'd7;
    @(negedge clk); push = 1'b0;
    chk("t3_drop", int'(drop), 1);
    chk("t3_count", int'(count), 0);
    @(negedge clk);
    chk("t3_drop_pulse", int'(drop), 0);
    chk("t3_no_launch", int'(busy), 0);

    // Five back-to-back pushes with no acks: first launches, four remain.
    for (int i = 0; i < 5; i++) begin
      px[i] = $urandom_range(1, 15);
      py[i] = $urandom_range(1, 15);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); push = 1'b1; X_push = W'(px[i]); Y_push = W'(py[i]);
    end
    @(negedge clk);
    chk("t2_count", int'(count), 4);
    chk("t2_full", int'(full), 1);
    X_push = 4'd3; Y_push = 4'd5;
    @(posedge clk); #1;
    chk("t2_drop", int'(drop), 1);
    chk("t2_count_kept", int'(count), 4);
    @(negedge clk); push = 1'b0;

    // Unacknowledged result blocks the next launch.
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk); seen = res_valid;
    end
    chk("t4_valid", int'(res_valid), 1);
    chk("t4_gcd", int'(res_gcd), gcd(px[0], py[0]));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t4_start_held", int'(Start), 1);
      chk("t4_x_held", int'(X_out), px[0]);
      chk("t4_count_held", int'(count), 4);
    end

    // Random traffic with random acks.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      push    = ($urandom_range(0, 2) == 0);
      X_push  = W'($urandom_range(0, 15));
      Y_push  = W'($urandom_range(0, 15));
      res_ack = ($urandom_range(0, 1) == 1);
    end

    // Asynchronous reset in the middle of WAIT.
    core_hang = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen    = Start && busy && !res_valid;
      res_ack = !seen;
      push    = !seen && (count == 0);
      X_push  = 4'd10; Y_push = 4'd4;
    end
    chk("t5_reached_wait", int'(seen), 1);
    #2 reset = 1'b0;
    #1;
    chk("t5_start", int'(Start), 0);
    chk("t5_valid", int'(res_valid), 0);
    chk("t5_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    core_hang = 1'b0;
    @(posedge clk); #1;
    chk("t5_count", int'(count), 0);
    chk("t5_idle", int'(busy), 0);

`ifdef GCD_FEED_TIMEOUT_EN
    // Watchdog: core never answers.
    core_hang = 1'b1;
    @(negedge clk); push = 1'b1; X_push = 4'd6; Y_push = 4'd4;
    @(negedge clk); push = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk); seen = res_valid;
    end
    chk("t6_valid", int'(res_valid), 1);
    chk("t6_err", int'(res_err), 1);
    chk("t6_gcd", int'(res_gcd), 0);
    res_ack = 1'b1;
    @(negedge clk); res_ack = 1'b0;
    chk("t6_err_clear", int'(res_err), 0);
    core_hang = 1'b0;
`endif

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
